// File: rtl/sigma_boot_memory.sv
// Main word memory for the Sigma CPU. After reset a byte-stream boot loader fills memory while
// holding the CPU in reset; once the image is in, the CPU is released and served directly.
module sigma_boot_memory #(
  parameter int unsigned ADDR_BITS     = 12,
  parameter int unsigned LOAD_BASE     = 0,
  parameter int unsigned RELEASE_DELAY = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [0:7]   ld_data,
  input  logic         ld_valid,
  input  logic         ld_last,
  output logic         ld_ready,
  output logic         cpu_reset,
  input  logic [15:31] memory_address,
  input  logic [0:31]  memory_data_in,
  input  logic [0:3]   wr_enables,
  output logic [0:31]  memory_data_out,
  output logic         load_done,
  output logic         load_error,
  output logic [15:31] word_count
);

  localparam int unsigned Depth = 2 ** ADDR_BITS;

  typedef enum logic [1:0] {StLoad, StRelease, StRun} state_e;

  state_e      state_q, state_d;
  logic [1:0]  lane_q, lane_d;
  logic [0:31] asm_q, asm_d;
  logic [16:0] ptr_q, ptr_d;
  logic [16:0] count_q, count_d;
  logic [3:0]  rel_q, rel_d;
  logic        err_q, err_d;

  logic [0:31] mem_q [Depth];

  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_waddr;
  logic [0:31]          mem_wdata;
  logic [0:3]           mem_wstrb;

  logic [16:0] cpu_addr;
  logic        cpu_in_range;
  logic        ptr_in_range;
  logic        accept;
  logic        word_done;
  logic [0:31] word_full;

  assign cpu_addr     = memory_address;
  // Range checks use the full 17-bit value so wrapped or out-of-range addresses never alias.
  assign cpu_in_range = (32'(cpu_addr) >> ADDR_BITS) == 32'd0;
  assign ptr_in_range = (32'(ptr_q) >> ADDR_BITS) == 32'd0;
  assign accept       = (state_q == StLoad) && ld_valid;
  assign word_done    = accept && ((lane_q == 2'd3) || ld_last);

  // Current byte merged into the assembly word; unfilled lanes are still zero.
  always_comb begin
    word_full = asm_q;
    word_full[{lane_q, 3'b000} +: 8] = ld_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StLoad;
      lane_q  <= 2'd0;
      asm_q   <= '0;
      ptr_q   <= 17'(LOAD_BASE);
      count_q <= '0;
      rel_q   <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      asm_q   <= asm_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      rel_q   <= rel_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StLoad:    if (accept && ld_last) state_d = StRelease;
      StRelease: if (rel_q == 4'd0) state_d = StRun;
      StRun:     state_d = StRun;
      default:   state_d = StLoad;
    endcase
  end

  always_comb begin
    lane_d    = lane_q;
    asm_d     = asm_q;
    ptr_d     = ptr_q;
    count_d   = count_q;
    err_d     = err_q;
    rel_d     = rel_q;
    mem_we    = 1'b0;
    mem_waddr = ptr_q[ADDR_BITS-1:0];
    mem_wdata = word_full;
    mem_wstrb = 4'b1111;
    if (accept) begin
      if (word_done) begin
        lane_d = 2'd0;
        asm_d  = '0;
        ptr_d  = ptr_q + 17'd1;
        if (ptr_in_range) begin
          mem_we  = 1'b1;
          count_d = count_q + 17'd1;
        end else begin
          err_d = 1'b1;
        end
      end else begin
        lane_d = lane_q + 2'd1;
        asm_d  = word_full;
      end
      if (ld_last) rel_d = 4'(RELEASE_DELAY - 1);
    end else if ((state_q == StRelease) && (rel_q != 4'd0)) begin
      rel_d = rel_q - 4'd1;
    end
    if (state_q == StRun) begin
      mem_we    = cpu_in_range && (|wr_enables);
      mem_waddr = cpu_addr[ADDR_BITS-1:0];
      mem_wdata = memory_data_in;
      mem_wstrb = wr_enables;
    end
  end

  // No write may land on a reset edge: a half-built load or stale CPU store is dropped.
  always_ff @(posedge clock) begin
    if (mem_we && !reset) begin
      for (int k = 0; k < 4; k++) begin
        if (mem_wstrb[k]) mem_q[mem_waddr][8*k +: 8] <= mem_wdata[8*k +: 8];
      end
    end
  end

  always_comb begin
    ld_ready  = (state_q == StLoad);
    cpu_reset = (state_q != StRun);
    load_done = (state_q == StRun);
  end

  assign load_error      = err_q;
  assign word_count      = count_q;
  assign memory_data_out = cpu_in_range ? mem_q[cpu_addr[ADDR_BITS-1:0]] : '0;

endmodule

// File: tb/tb_sigma_boot_memory.sv
// Bench for sigma_boot_memory: a 4096-word and a 4-word instance share all stimulus and are
// checked against an image-level model of what the loader and CPU writes should leave behind.
module tb_sigma_boot_memory;

  localparam int RelDelay = 2;
  localparam int BigDepth = 4096;
  localparam int SmlDepth = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic [0:7]   ld_data;
  logic         ld_valid;
  logic         ld_last;
  logic [15:31] memory_address;
  logic [0:31]  memory_data_in;
  logic [0:3]   wr_enables;

  logic         b_ld_ready, b_cpu_reset, b_done, b_err;
  logic [0:31]  b_rdata;
  logic [15:31] b_wc;
  logic         s_ld_ready, s_cpu_reset, s_done, s_err;
  logic [0:31]  s_rdata;
  logic [15:31] s_wc;

  always #5 clock = ~clock;

  sigma_boot_memory #(.ADDR_BITS(12), .LOAD_BASE(0), .RELEASE_DELAY(RelDelay)) u_big (
    .clock(clock), .reset(reset), .ld_data(ld_data), .ld_valid(ld_valid), .ld_last(ld_last),
    .ld_ready(b_ld_ready), .cpu_reset(b_cpu_reset), .memory_address(memory_address),
    .memory_data_in(memory_data_in), .wr_enables(wr_enables), .memory_data_out(b_rdata),
    .load_done(b_done), .load_error(b_err), .word_count(b_wc)
  );

  sigma_boot_memory #(.ADDR_BITS(2), .LOAD_BASE(0), .RELEASE_DELAY(RelDelay)) u_small (
    .clock(clock), .reset(reset), .ld_data(ld_data), .ld_valid(ld_valid), .ld_last(ld_last),
    .ld_ready(s_ld_ready), .cpu_reset(s_cpu_reset), .memory_address(memory_address),
    .memory_data_in(memory_data_in), .wr_enables(wr_enables), .memory_data_out(s_rdata),
    .load_done(s_done), .load_error(s_err), .word_count(s_wc)
  );

  int unsigned n_err = 0;
  int unsigned n_chk = 0;

  // Known memory contents; absent keys are words whose value is undefined.
  logic [31:0] m_big [int];
  logic [31:0] m_sml [int];
  int exp_wc_big, exp_wc_sml;
  bit exp_err_big, exp_err_sml;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic scramble_cpu();
    memory_address = 17'($urandom_range(0, 7));
    wr_enables     = 4'($urandom);
    memory_data_in = $urandom;
  endtask

  task automatic check_read(input string tag, input int a);
    memory_address = 17'(a);
    #1;
    if (a >= BigDepth) check_eq({tag, "_big_oor"}, b_rdata, 32'h0);
    else if (m_big.exists(a)) check_eq({tag, "_big"}, b_rdata, m_big[a]);
    if (a >= SmlDepth) check_eq({tag, "_sml_oor"}, s_rdata, 32'h0);
    else if (m_sml.exists(a)) check_eq({tag, "_sml"}, s_rdata, m_sml[a]);
  endtask

  task automatic verify_mem(input string tag);
    wr_enables = '0;
    foreach (m_big[a]) check_read(tag, a);
  endtask

  task automatic do_reset();
    reset = 1'b1; ld_valid = 1'b0; ld_last = 1'b0; wr_enables = '0;
    step();
    reset = 1'b0;
    check_eq("rst_cpu_reset", {b_cpu_reset, s_cpu_reset}, 2'b11);
    check_eq("rst_ld_ready", {b_ld_ready, s_ld_ready}, 2'b11);
    check_eq("rst_load_done", {b_done, s_done}, 2'b00);
    check_eq("rst_load_error", {b_err, s_err}, 2'b00);
    check_eq("rst_wc_big", b_wc, 0);
    check_eq("rst_wc_sml", s_wc, 0);
  endtask

  task automatic check_loading();
    check_eq("load_cpu_reset", {b_cpu_reset, s_cpu_reset}, 2'b11);
    check_eq("load_ld_ready", {b_ld_ready, s_ld_ready}, 2'b11);
    check_eq("load_done_low", {b_done, s_done}, 2'b00);
  endtask

  // Image-level model: bytes pack big-endian into words stored from address 0 upward.
  task automatic model_commit(input logic [7:0] bytes[$], input bit aborted);
    int n = bytes.size();
    int words = aborted ? n / 4 : (n + 3) / 4;
    for (int w = 0; w < words; w++) begin
      logic [31:0] word = '0;
      for (int b = 0; b < 4; b++) begin
        int idx = 4 * w + b;
        word = {word[23:0], (idx < n) ? bytes[idx] : 8'h00};
      end
      if (w < BigDepth) m_big[w] = word;
      if (w < SmlDepth) m_sml[w] = word;
    end
    exp_wc_big  = (words < BigDepth) ? words : BigDepth;
    exp_wc_sml  = (words < SmlDepth) ? words : SmlDepth;
    exp_err_big = words > BigDepth;
    exp_err_sml = words > SmlDepth;
  endtask

  // gap: 0 = back-to-back, 1 = one idle cycle before each byte, 2 = random idle cycles.
  task automatic load_image(input logic [7:0] bytes[$], input int gap, input bit abort);
    int n = bytes.size();
    for (int i = 0; i < n; i++) begin
      int idle = (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
      for (int j = 0; j < idle; j++) begin
        ld_valid = 1'b0; ld_last = 1'($urandom); ld_data = 8'($urandom);
        scramble_cpu();
        check_loading();
        step();
      end
      ld_valid = 1'b1; ld_data = bytes[i]; ld_last = (i == n - 1) && !abort;
      scramble_cpu();
      check_loading();
      step();
    end
    ld_valid = 1'b0; ld_last = 1'b0; wr_enables = '0;
    model_commit(bytes, abort);
  endtask

  task automatic check_release();
    for (int r = 0; r < RelDelay; r++) begin
      check_eq("rel_cpu_reset", {b_cpu_reset, s_cpu_reset}, 2'b11);
      check_eq("rel_ld_ready", {b_ld_ready, s_ld_ready}, 2'b00);
      ld_valid = 1'($urandom); ld_last = 1'($urandom); ld_data = 8'($urandom);
      scramble_cpu();
      step();
    end
    wr_enables = '0;
    check_eq("run_cpu_reset", {b_cpu_reset, s_cpu_reset}, 2'b00);
    check_eq("run_load_done", {b_done, s_done}, 2'b11);
    check_eq("run_ld_ready", {b_ld_ready, s_ld_ready}, 2'b00);
    check_eq("run_wc_big", b_wc, 32'(exp_wc_big));
    check_eq("run_wc_sml", s_wc, 32'(exp_wc_sml));
    check_eq("run_err_big", b_err, exp_err_big);
    check_eq("run_err_sml", s_err, exp_err_sml);
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic model_write(input int a, input logic [0:3] en, input logic [31:0] d);
    logic [31:0] w;
    if (a < BigDepth && (m_big.exists(a) || en == 4'b1111)) begin
      w = m_big.exists(a) ? m_big[a] : 32'h0;
      for (int k = 0; k < 4; k++) if (en[k]) w[31-8*k -: 8] = d[31-8*k -: 8];
      m_big[a] = w;
    end
    if (a < SmlDepth && (m_sml.exists(a) || en == 4'b1111)) begin
      w = m_sml.exists(a) ? m_sml[a] : 32'h0;
      for (int k = 0; k < 4; k++) if (en[k]) w[31-8*k -: 8] = d[31-8*k -: 8];
      m_sml[a] = w;
    end
  endtask

  task automatic cpu_write(input string tag, input int a, input logic [0:3] en,
                           input logic [31:0] d);
    wr_enables = en; memory_data_in = d;
    ld_valid = 1'($urandom); ld_last = 1'($urandom); ld_data = 8'($urandom);
    check_read({tag, "_pre"}, a);
    step();
    wr_enables = '0;
    model_write(a, en, d);
    check_read({tag, "_post"}, a);
  endtask

  task automatic run_random_ops(input int n);
    for (int i = 0; i < n; i++) begin
      int a = ($urandom_range(0, 7) == 0) ? int'($urandom_range(BigDepth, 131071))
                                          : int'($urandom_range(0, 7));
      cpu_write("rnd", a, 4'($urandom), $urandom);
    end
    check_eq("rnd_wc_big", b_wc, 32'(exp_wc_big));
    check_eq("rnd_done", {b_done, s_done}, 2'b11);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] img[$];
    reset = 1'b1; ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0;
    memory_address = '0; memory_data_in = '0; wr_enables = '0;
    step();
    do_reset();

    img = '{8'h22, 8'h10, 8'h00, 8'h05, 8'h2E, 8'h00, 8'h00, 8'h00};
    load_image(img, 0, 1'b0);
    check_release();
    verify_mem("t1");
    check_read("t1_mem0", 0);
    check_eq("t1_mem0_const", b_rdata, 32'h22100005);
    check_read("t1_mem1", 1);
    check_eq("t1_mem1_const", b_rdata, 32'h2E000000);

    cpu_write("t3_init", 3, 4'b1111, 32'h12345678);
    cpu_write("t3_lanes", 3, 4'b0101, 32'hFFFFFFFF);
    check_eq("t3_mem3_const", b_rdata, 32'h12FF56FF);
    run_random_ops(150);

    do_reset();
    img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11};
    load_image(img, 1, 1'b0);
    check_release();
    verify_mem("t2");
    check_read("t2_mem0", 0);
    check_eq("t2_mem0_const", b_rdata, 32'hAABBCCDD);

    do_reset();
    img = {};
    for (int i = 0; i < 20; i++) img.push_back(8'($urandom));
    load_image(img, 0, 1'b0);
    check_release();
    check_eq("ovf_err_sml", s_err, 1'b1);
    check_eq("ovf_wc_sml", s_wc, 4);
    check_read("ovf_addr4", 4);
    verify_mem("ovf");

    do_reset();
    img = {};
    for (int i = 0; i < 6; i++) img.push_back(8'($urandom));
    load_image(img, 0, 1'b1);
    do_reset();
    img = '{8'h5A, 8'hC3, 8'h0F, 8'h96};
    load_image(img, 2, 1'b0);
    check_release();
    check_read("abort_mem0", 0);
    check_eq("abort_mem0_const", b_rdata, 32'h5AC30F96);
    check_eq("abort_wc", b_wc, 1);

    do_reset();
    memory_address = '0; wr_enables = 4'b1111; memory_data_in = ~m_big[0];
    for (int i = 0; i < 3; i++) step();
    check_read("ldwr_mem0", 0);

    for (int r = 0; r < 4; r++) begin
      img = {};
      for (int i = 0, n = $urandom_range(1, 24); i < n; i++) img.push_back(8'($urandom));
      load_image(img, 2, 1'b0);
      check_release();
      verify_mem("rld");
      run_random_ops(40);
      do_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
